// File: rtl/ei_div_pkg.sv
// ei_divider shared types and helpers.
// State encoding, counter sizing and divide-by-zero fill.
package ei_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Every quotient bit is set on a divide by zero.
  localparam logic DBZ_QUOT_BIT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ei_div_step.sv
// One radix-2 restoring division iteration.
// Pure combinational; the remainder always fits in WIDTH_D bits.
module ei_div_step
  import ei_div_pkg::*;
#(
  parameter int WIDTH_D = 8
) (
  input  logic [WIDTH_D-1:0] r,
  input  logic               q_msb,
  input  logic [WIDTH_D-1:0] d,
  output logic [WIDTH_D-1:0] r_next,
  output logic               q_bit
);

  logic [WIDTH_D:0] t;

  assign t = {r, q_msb};
  assign q_bit = (t >= {1'b0, d});
  // T-D < D here, so the low bits of the difference are exact.
  assign r_next = q_bit ? (t[WIDTH_D-1:0] - d)
                        : t[WIDTH_D-1:0];

endmodule

// File: rtl/ei_divider.sv
// Sequential unsigned restoring divider, valid/ready on both ends.
// Optional dbz output flag under macro EI_DIV_DBZ_FLAG_EN.
module ei_divider
  import ei_div_pkg::*;
#(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder
`ifdef EI_DIV_DBZ_FLAG_EN
  ,
  output logic               dbz
`endif
);

  localparam int CW = clog2(WIDTH_N);

  state_t state, state_next;

  logic [WIDTH_N-1:0] q;
  logic [WIDTH_N-1:0] q_shift;
  logic [WIDTH_D-1:0] r;
  logic [WIDTH_D-1:0] d;
  logic [WIDTH_D-1:0] r_next;
  logic               q_bit;
  logic [CW-1:0]      cnt;
  logic               dz;
  logic               last;

  assign dz = (divisor == '0);
  assign last = (cnt == '0);
  assign q_shift = {q[WIDTH_N-2:0], q_bit};

  ei_div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .r      (r),
    .q_msb  (q[WIDTH_N-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // State register; rst wins over en.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else if (en) state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (en && in_valid)
          state_next = dz ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (en && last) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (en && out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latch, iteration registers and held result.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (en) begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            q   <= dividend;
            d   <= divisor;
            r   <= '0;
            cnt <= CW'(WIDTH_N - 1);
            if (dz) begin
              quotient  <= {WIDTH_N{DBZ_QUOT_BIT}};
              remainder <= dividend[WIDTH_D-1:0];
            end
          end
        end
        ST_CALC: begin
          q   <= q_shift;
          r   <= r_next;
          cnt <= cnt - 1'b1;
          if (last) begin
            quotient  <= q_shift;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EI_DIV_DBZ_FLAG_EN
  // Tags the held result as a divide-by-zero outcome.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      dbz <= 1'b0;
    end else if (en) begin
      if (state == ST_IDLE && in_valid) dbz <= dz;
      else if (state == ST_DONE && out_ready) dbz <= 1'b0;
    end
  end
`endif

endmodule
